// File: rtl/fetch_queue.sv
// Decoupling queue between the fetch and decode stages.
// Buffers {pc, instruction} pairs in a circular buffer and pushes back on
// the fetch stage when full. A taken branch flushes everything queued.
module fetch_queue #(
  parameter int BIT_NUMBER = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch_taken,
  input  logic [BIT_NUMBER-1:0]      if_pc,
  input  logic [BIT_NUMBER-1:0]      if_instruction,
  output logic                       freeze,
  input  logic                       id_freeze,
  output logic                       id_valid,
  output logic [BIT_NUMBER-1:0]      id_pc,
  output logic [BIT_NUMBER-1:0]      id_instruction,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BIT_NUMBER-1:0] pc_mem_q  [DEPTH];
  logic [BIT_NUMBER-1:0] ins_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Status flags come only from registered occupancy, so freeze never
  // depends combinationally on the fetch or decode inputs.
  always_comb begin
    freeze   = (count_q == CNT_W'(DEPTH));
    id_valid = (count_q != '0);
    push     = !freeze && !branch_taken;
    pop      = id_valid && !id_freeze && !branch_taken;
  end

  // Head entry is masked to zero when empty; storage itself is never reset.
  always_comb begin
    id_pc          = '0;
    id_instruction = '0;
    if (id_valid) begin
      id_pc          = pc_mem_q[rd_ptr_q];
      id_instruction = ins_mem_q[rd_ptr_q];
    end
  end

  // Next-state for pointers and occupancy; a flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (branch_taken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write; contents are only observed through the masked head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= if_pc;
      ins_mem_q[wr_ptr_q] <= if_instruction;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) with a queue-based reference.
module tb_fetch_queue;

  localparam int BW = 32;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          branch_taken;
  logic [BW-1:0] if_pc;
  logic [BW-1:0] if_instruction;
  logic          freeze;
  logic          id_freeze;
  logic          id_valid;
  logic [BW-1:0] id_pc;
  logic [BW-1:0] id_instruction;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;
  logic [63:0] mq[$];

  fetch_queue #(.BIT_NUMBER(BW), .DEPTH(DP)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .freeze         (freeze),
    .id_freeze      (id_freeze),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic [63:0] head;
    head = (mq.size() != 0) ? mq[0] : 64'h0;
    chk({tag, "_cnt"},   64'(count),          64'(mq.size()));
    chk({tag, "_frz"},   64'(freeze),         64'(mq.size() == DP));
    chk({tag, "_vld"},   64'(id_valid),       64'(mq.size() != 0));
    chk({tag, "_pc"},    64'(id_pc),          {32'h0, head[63:32]});
    chk({tag, "_instr"}, 64'(id_instruction), {32'h0, head[31:0]});
  endtask

  // One clock: drive inputs, predict from the reference queue, check after edge.
  task automatic cycle(input logic [BW-1:0] pc, input logic bt, input logic idf,
                       input string tag);
    bit full, push, pop;
    if_pc          = pc;
    if_instruction = ~pc;
    branch_taken   = bt;
    id_freeze      = idf;
    full = (mq.size() == DP);
    push = !full && !bt;
    pop  = (mq.size() != 0) && !idf && !bt;
    @(posedge clk);
    if (bt) mq.delete();
    else begin
      if (pop)  mq.delete(0);
      if (push) mq.push_back({pc, ~pc});
    end
    #1;
    model_check(tag);
  endtask

  initial begin
    logic [9:0] wrap_frz;
    rst = 1'b1; branch_taken = 1'b0; id_freeze = 1'b1;
    if_pc = '0; if_instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(id_valid), 64'h0);
    chk("rst_cnt", 64'(count),    64'h0);
    chk("rst_frz", 64'(freeze),   64'h0);
    chk("rst_pc",  64'(id_pc),    64'h0);
    rst = 1'b0;

    // Fill with decode stalled: pc 20 must be refused.
    cycle(32'd4,  1'b0, 1'b1, "fill1"); chk("fill1_hc", 64'(count), 64'd1);
    chk("fill1_lat", 64'(id_pc), 64'd4);
    cycle(32'd8,  1'b0, 1'b1, "fill2"); chk("fill2_hc", 64'(count), 64'd2);
    cycle(32'd12, 1'b0, 1'b1, "fill3"); chk("fill3_hc", 64'(count), 64'd3);
    cycle(32'd16, 1'b0, 1'b1, "fill4"); chk("fill4_hc", 64'(count), 64'd4);
    chk("fill4_frz", 64'(freeze), 64'd1);
    cycle(32'd20, 1'b0, 1'b1, "fill5"); chk("fill5_hc", 64'(count), 64'd4);
    chk("fill5_pc", 64'(id_pc), 64'd4);

    // Drain with fetch still running: heads 8,12,16 follow 4 in order.
    cycle(32'd24, 1'b0, 1'b0, "drn1"); chk("drn1_pc", 64'(id_pc), 64'd8);
    chk("drn1_frz", 64'(freeze), 64'd0); chk("drn1_cnt", 64'(count), 64'd3);
    cycle(32'd28, 1'b0, 1'b0, "drn2"); chk("drn2_pc", 64'(id_pc), 64'd12);
    cycle(32'd32, 1'b0, 1'b0, "drn3"); chk("drn3_pc", 64'(id_pc), 64'd16);
    chk("drn3_cnt", 64'(count), 64'd3);

    // Flush from count 3, then first post-flush word is the next one presented.
    cycle(32'h100, 1'b1, 1'b0, "fl1");
    chk("fl1_cnt", 64'(count), 64'd0); chk("fl1_vld", 64'(id_valid), 64'd0);
    chk("fl1_pc", 64'(id_pc), 64'd0);
    cycle(32'h200, 1'b0, 1'b0, "fl2");
    chk("fl2_cnt", 64'(count), 64'd1); chk("fl2_pc", 64'(id_pc), 64'h200);

    // Steady flow: occupancy 1, head is last presented pc.
    for (int i = 1; i <= 4; i++) begin
      cycle(32'h200 + 32'(4 * i), 1'b0, 1'b0, "stdy");
      chk("stdy_cnt", 64'(count), 64'd1);
      chk("stdy_pc",  64'(id_pc), 64'(32'h200 + 32'(4 * i)));
    end

    // Async reset between edges with two entries queued.
    cycle(32'h300, 1'b0, 1'b1, "pre_rst"); chk("pre_rst_cnt", 64'(count), 64'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_vld", 64'(id_valid), 64'd0);
    chk("arst_cnt", 64'(count),    64'd0);
    chk("arst_frz", 64'(freeze),   64'd0);
    chk("arst_pc",  64'(id_pc),    64'd0);
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_check("post_rst");

    // Wrap-around with mixed decode stalls.
    wrap_frz = 10'b1001110110;
    for (int i = 0; i < 10; i++)
      cycle(32'h400 + 32'(4 * i), 1'b0, wrap_frz[i], "wrap");
    for (int i = 0; i < 4; i++)
      cycle(32'h500 + 32'(4 * i), 1'b0, 1'b1, "full2");
    chk("full2_frz", 64'(freeze), 64'd1);
    cycle(32'h600, 1'b1, 1'b0, "flfull");
    chk("flfull_cnt", 64'(count), 64'd0);
    cycle(32'h604, 1'b0, 1'b0, "flfull2");
    chk("flfull2_pc", 64'(id_pc), 64'h604);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter BIT_NUMBER, default 32: width of PC and instruction words.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 branch_taken  input  1  flush request; same signal that redirects the fetch stage.
REQ-006 if_pc  input  BIT_NUMBER  fetch-stage PC output (address of fetched instruction + 4).
REQ-007 if_instruction  input  BIT_NUMBER  fetch-stage instruction word.
REQ-008 freeze  output  1  back-pressure to the fetch stage; high holds the PC register.
REQ-009 id_freeze  input  1  decode-side stall; high blocks dequeue.
REQ-010 id_valid  output  1  head entry present.
REQ-011 id_pc  output  BIT_NUMBER  head entry PC.
REQ-012 id_instruction  output  BIT_NUMBER  head entry instruction.
REQ-013 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 Storage: circular buffer of DEPTH {pc, instruction} entries; write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-015 freeze = (count == DEPTH), combinational from registered occupancy only.
REQ-016 push = !freeze && !branch_taken; push writes {if_pc, if_instruction} at the write pointer, then the write pointer advances by 1.
REQ-017 pop = id_valid && !id_freeze && !branch_taken; pop advances the read pointer by 1.
REQ-018 id_valid = (count != 0); id_pc and id_instruction are the entry at the read pointer when id_valid=1 and are all zeros when id_valid=0.
REQ-019 Latency: a word pushed at edge N is visible on id_* after edge N when the queue was empty; there is no combinational bypass from if_* to id_*.
REQ-020 Occupancy update: push only -> +1; pop only -> -1; push and pop in the same cycle -> unchanged.
REQ-021 Full with pop: freeze=1, so there is no push; count goes DEPTH -> DEPTH-1; freeze deasserts the following cycle.
REQ-022 Empty: pop is impossible; push only -> count 0 -> 1.
REQ-023 Flush: branch_taken=1 at an edge sets count=0 and both pointers=0, with no push and no pop; flush has priority over every other event.
REQ-024 After a flush, id_valid=0 for at least one cycle; the first post-flush entry is the word presented on the cycle after branch_taken deasserts.
REQ-025 Ordering: entries leave in strict push order; no duplication, no loss while rst=0 and branch_taken=0.
REQ-026 Count never exceeds DEPTH and never underflows, under any input sequence.

Reset
REQ-027 rst=1 immediately, without waiting for clk, forces count=0, both pointers=0, id_valid=0, id_pc=0, id_instruction=0 and freeze=0.
REQ-028 Entry storage requires no reset; outputs are masked by REQ-018.
REQ-029 rst asserted mid-operation discards all entries; operation resumes at the first rising edge after deassertion, as from an empty queue.
REQ-030 rst overrides branch_taken and all push/pop activity.

Verification
REQ-031 Fill: DEPTH=4, id_freeze=1, if_pc=4,8,12,16,20 on successive cycles -> count 1,2,3,4,4; freeze=1 after the 4th edge; the queue holds pc 4..16; pc 20 is not stored.
REQ-032 Drain: from the full state, id_freeze=0 -> id_pc sequence 4,8,12,16 on consecutive cycles, with freeze dropping after the first pop; then id_valid=0 with id_pc=0.
REQ-033 Steady flow: id_freeze=0 with continuous fetch -> count holds at 1 and id_pc tracks if_pc with a 1-cycle delay.
REQ-034 Flush: count=3, pulse branch_taken for 1 cycle with if_pc=0x100 -> count=0 and id_valid=0 next cycle; the next entry is the word presented on the following cycle.
REQ-035 Async reset: assert rst between clock edges with count=2 -> id_valid=0, count=0 and freeze=0 before the next edge.
REQ-036 Wrap: 10 push/pop cycles with mixed id_freeze -> pointer wrap-around, with output order matching a reference model exactly.
